// File: rtl/pool2x2_window_gen_if.sv
// Bus bundle between the conv/activation stage, the 2x2 window generator
// and the max-pool unit: an unthrottled pixel stream in, 2x2 windows out.
interface pool2x2_window_gen_if #(
    parameter int DATA_W = 8
);
    logic                     in_valid;
    logic signed [DATA_W-1:0] in_data;
    logic signed [DATA_W-1:0] p00;
    logic signed [DATA_W-1:0] p01;
    logic signed [DATA_W-1:0] p10;
    logic signed [DATA_W-1:0] p11;
    logic                     out_valid;
    logic                     frame_done;

    // Upstream side: drives pixels and observes windows
    modport master (
        output in_valid, in_data,
        input  p00, p01, p10, p11, out_valid, frame_done
    );

    // Window generator side: consumes pixels and produces windows
    modport slave (
        input  in_valid, in_data,
        output p00, p01, p10, p11, out_valid, frame_done
    );
endinterface

// File: rtl/pool2x2_window_gen.sv
// 2x2 stride-2 window generator for the max-pool stage. Even rows are stored
// in a one-line buffer; on odd rows the even-column pixel is held and the
// odd-column pixel completes a window that is registered out one cycle later.
module pool2x2_window_gen #(
    parameter int DATA_W = 8,
    parameter int IMG_W  = 28,
    parameter int IMG_H  = 28
) (
    input  logic                 clk,
    input  logic                 rst,
    pool2x2_window_gen_if.slave  bus
);
    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    // Position of the p11 pixel of the frame's final window; a trailing odd
    // row/column lies beyond it and never contributes to a window.
    localparam logic [CW-1:0] COL_FINAL_WIN = CW'(2 * (IMG_W / 2) - 1);
    localparam logic [RW-1:0] ROW_FINAL_WIN = RW'(2 * (IMG_H / 2) - 1);

    logic signed [DATA_W-1:0] lineBuf [IMG_W];

    logic [CW-1:0]            col_q, col_d;
    logic [RW-1:0]            row_q, row_d;
    logic signed [DATA_W-1:0] hold_q, hold_d;
    logic signed [DATA_W-1:0] p00_q, p00_d;
    logic signed [DATA_W-1:0] p01_q, p01_d;
    logic signed [DATA_W-1:0] p10_q, p10_d;
    logic signed [DATA_W-1:0] p11_q, p11_d;
    logic                     outValid_q, outValid_d;
    logic                     frameDone_q, frameDone_d;

    logic                     bufWrite;
    logic                     windowBeat;

    // Next-state: raster counters, line-buffer/hold capture and window assembly
    always_comb begin
        col_d       = col_q;
        row_d       = row_q;
        hold_d      = hold_q;
        p00_d       = p00_q;
        p01_d       = p01_q;
        p10_d       = p10_q;
        p11_d       = p11_q;
        bufWrite    = 1'b0;
        windowBeat  = bus.in_valid & row_q[0] & col_q[0];
        outValid_d  = windowBeat;
        frameDone_d = windowBeat && (row_q == ROW_FINAL_WIN) && (col_q == COL_FINAL_WIN);

        if (bus.in_valid) begin
            if (col_q == COL_LAST) begin
                col_d = '0;
                row_d = (row_q == ROW_LAST) ? '0 : row_q + RW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end

            if (!row_q[0]) begin
                bufWrite = 1'b1;
            end else if (!col_q[0]) begin
                hold_d = bus.in_data;
            end
        end

        if (windowBeat) begin
            p00_d = lineBuf[col_q - CW'(1)];
            p01_d = lineBuf[col_q];
            p10_d = hold_q;
            p11_d = bus.in_data;
        end
    end

    // Line buffer holds the most recent even row; contents need no reset
    always_ff @(posedge clk) begin
        if (bufWrite) begin
            lineBuf[col_q] <= bus.in_data;
        end
    end

    // State and registered window outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col_q       <= '0;
            row_q       <= '0;
            hold_q      <= '0;
            p00_q       <= '0;
            p01_q       <= '0;
            p10_q       <= '0;
            p11_q       <= '0;
            outValid_q  <= 1'b0;
            frameDone_q <= 1'b0;
        end else begin
            col_q       <= col_d;
            row_q       <= row_d;
            hold_q      <= hold_d;
            p00_q       <= p00_d;
            p01_q       <= p01_d;
            p10_q       <= p10_d;
            p11_q       <= p11_d;
            outValid_q  <= outValid_d;
            frameDone_q <= frameDone_d;
        end
    end

    assign bus.p00        = p00_q;
    assign bus.p01        = p01_q;
    assign bus.p10        = p10_q;
    assign bus.p11        = p11_q;
    assign bus.out_valid  = outValid_q;
    assign bus.frame_done = frameDone_q;
endmodule

// File: tb/tb_pool2x2_window_gen.sv
// Self-checking bench for pool2x2_window_gen: three instances (4x4, 2x2, 5x3)
// are driven with directed and random pixel streams and compared against a
// window list computed directly from the frame geometry.
module tb_pool2x2_window_gen;
    localparam int DW = 8;

    typedef struct packed {
        logic signed [DW-1:0] a;
        logic signed [DW-1:0] b;
        logic signed [DW-1:0] c;
        logic signed [DW-1:0] d;
        logic                 fd;
    } win_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    int   strayFd = 0;

    win_t cap4[$], cap2[$], cap53[$];
    int   capCyc4[$], capCyc2[$], capCyc53[$];
    win_t expQ[$];
    int   expBeat[$];
    int   beatCyc[$];

    pool2x2_window_gen_if #(.DATA_W(DW)) bus4  ();
    pool2x2_window_gen_if #(.DATA_W(DW)) bus2  ();
    pool2x2_window_gen_if #(.DATA_W(DW)) bus53 ();

    pool2x2_window_gen #(.DATA_W(DW), .IMG_W(4), .IMG_H(4)) u4 (
        .clk(clk), .rst(rst), .bus(bus4));
    pool2x2_window_gen #(.DATA_W(DW), .IMG_W(2), .IMG_H(2)) u2 (
        .clk(clk), .rst(rst), .bus(bus2));
    pool2x2_window_gen #(.DATA_W(DW), .IMG_W(5), .IMG_H(3)) u53 (
        .clk(clk), .rst(rst), .bus(bus53));

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every emitted window with the cycle it was seen in
    always @(negedge clk) begin
        if (bus4.out_valid === 1'b1) begin
            cap4.push_back({bus4.p00, bus4.p01, bus4.p10, bus4.p11, bus4.frame_done});
            capCyc4.push_back(cyc);
        end else if (bus4.frame_done !== 1'b0) strayFd++;
        if (bus2.out_valid === 1'b1) begin
            cap2.push_back({bus2.p00, bus2.p01, bus2.p10, bus2.p11, bus2.frame_done});
            capCyc2.push_back(cyc);
        end else if (bus2.frame_done !== 1'b0) strayFd++;
        if (bus53.out_valid === 1'b1) begin
            cap53.push_back({bus53.p00, bus53.p01, bus53.p10, bus53.p11, bus53.frame_done});
            capCyc53.push_back(cyc);
        end else if (bus53.frame_done !== 1'b0) strayFd++;
    end

    // Reference: enumerate stride-2 windows of each frame in emission order
    task automatic buildModel(input int w, input int h, input logic signed [DW-1:0] pix[$]);
        int frames = pix.size() / (w * h);
        expQ.delete();
        expBeat.delete();
        for (int f = 0; f < frames; f++)
            for (int r = 0; r < h / 2; r++)
                for (int c = 0; c < w / 2; c++) begin
                    int top = f * w * h + 2 * r * w + 2 * c;
                    int bot = top + w;
                    expQ.push_back({pix[top], pix[top + 1], pix[bot], pix[bot + 1],
                                    (r == h / 2 - 1) && (c == w / 2 - 1)});
                    expBeat.push_back(bot + 1);
                end
    endtask

    task automatic setInput(input int sel, input logic v, input logic signed [DW-1:0] d);
        case (sel)
            0: begin bus4.in_valid  = v; bus4.in_data  = d; end
            1: begin bus2.in_valid  = v; bus2.in_data  = d; end
            default: begin bus53.in_valid = v; bus53.in_data = d; end
        endcase
    endtask

    task automatic clearCapture();
        cap4.delete(); cap2.delete(); cap53.delete();
        capCyc4.delete(); capCyc2.delete(); capCyc53.delete();
    endtask

    task automatic takeCapture(input int sel, output win_t got[$], output int gotCyc[$]);
        case (sel)
            0: begin got = cap4;  gotCyc = capCyc4;  end
            1: begin got = cap2;  gotCyc = capCyc2;  end
            default: begin got = cap53; gotCyc = capCyc53; end
        endcase
    endtask

    // Drive a pixel stream with up to gapMax random idle cycles before each beat
    task automatic driveStream(input int sel, input logic signed [DW-1:0] pix[$],
                               input int gapMax, input int settle);
        beatCyc.delete();
        foreach (pix[i]) begin
            int gaps = (gapMax > 0) ? int'($urandom_range(0, gapMax)) : 0;
            repeat (gaps) begin
                @(negedge clk);
                setInput(sel, 1'b0, DW'($urandom));
            end
            @(negedge clk);
            setInput(sel, 1'b1, pix[i]);
            beatCyc.push_back(cyc);
        end
        @(negedge clk);
        setInput(sel, 1'b0, '0);
        repeat (settle) @(negedge clk);
    endtask

    task automatic applyStimulus(input string name, input int sel, input int w, input int h,
                                 input logic signed [DW-1:0] pix[$], input int gapMax);
        win_t got[$];
        int   gotCyc[$];
        clearCapture();
        buildModel(w, h, pix);
        driveStream(sel, pix, gapMax, 4);
        takeCapture(sel, got, gotCyc);
        checks++;
        if (got.size() !== expQ.size()) begin
            errors++;
            $display("[TB] FAIL %s window count: got %0d expected %0d", name, got.size(), expQ.size());
        end
        foreach (expQ[i]) begin
            if (i < got.size()) begin
                checks++;
                if (got[i] !== expQ[i]) begin
                    errors++;
                    $display("[TB] FAIL %s window %0d: got %h expected %h", name, i, got[i], expQ[i]);
                end
                checks++;
                if (gotCyc[i] !== beatCyc[expBeat[i]] + 1) begin
                    errors++;
                    $display("[TB] FAIL %s latency %0d: got cycle %0d expected %0d",
                             name, i, gotCyc[i], beatCyc[expBeat[i]] + 1);
                end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        setInput(0, 1'b0, '0); setInput(1, 1'b0, '0); setInput(2, 1'b0, '0);
        repeat (2) @(negedge clk);
        checks++;
        if ({bus4.p00, bus4.p01, bus4.p10, bus4.p11, bus4.out_valid, bus4.frame_done} !== '0) begin
            errors++;
            $display("[TB] FAIL reset 4x4: got %h expected 0",
                     {bus4.p00, bus4.p01, bus4.p10, bus4.p11, bus4.out_valid, bus4.frame_done});
        end
        checks++;
        if ({bus53.p00, bus53.p01, bus53.p10, bus53.p11, bus53.out_valid, bus53.frame_done} !== '0) begin
            errors++;
            $display("[TB] FAIL reset 5x3: got %h expected 0",
                     {bus53.p00, bus53.p01, bus53.p10, bus53.p11, bus53.out_valid, bus53.frame_done});
        end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_continuous();
        logic signed [DW-1:0] pix[$];
        for (int i = 1; i <= 16; i++) pix.push_back(DW'(i));
        applyStimulus("continuous", 0, 4, 4, pix, 0);
    endtask

    task automatic test_gaps();
        logic signed [DW-1:0] pix[$];
        for (int i = 1; i <= 16; i++) pix.push_back(DW'(i));
        applyStimulus("gaps", 0, 4, 4, pix, 3);
    endtask

    task automatic test_signed();
        logic signed [DW-1:0] pix[$];
        pix = '{-8'sd8, -8'sd5, -8'sd10, -8'sd3};
        applyStimulus("signed", 1, 2, 2, pix, 0);
        checks++;
        if (cap2.size() != 1 || cap2[0] !== {-8'sd8, -8'sd5, -8'sd10, -8'sd3, 1'b1}) begin
            errors++;
            $display("[TB] FAIL signed literal: got %0d windows first %h expected f8fbf6fd1",
                     cap2.size(), (cap2.size() > 0) ? cap2[0] : '0);
        end
    endtask

    task automatic test_odd_dims();
        logic signed [DW-1:0] pix[$];
        for (int i = 1; i <= 15; i++) pix.push_back(DW'(i));
        applyStimulus("odd_dims", 2, 5, 3, pix, 0);
    endtask

    task automatic test_reset_mid_frame();
        logic signed [DW-1:0] pix[$];
        for (int i = 1; i <= 6; i++) pix.push_back(DW'(i));
        driveStream(0, pix, 0, 0);
        checks++;
        if (bus4.out_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL midreset pre: out_valid got %b expected 1", bus4.out_valid);
        end
        #1 rst = 1'b0;
        #1;
        checks++;
        if ({bus4.p00, bus4.p01, bus4.p10, bus4.p11, bus4.out_valid, bus4.frame_done} !== '0) begin
            errors++;
            $display("[TB] FAIL midreset async clear: got %h expected 0",
                     {bus4.p00, bus4.p01, bus4.p10, bus4.p11, bus4.out_valid, bus4.frame_done});
        end
        @(negedge clk);
        rst = 1'b1;
        pix.delete();
        for (int i = 1; i <= 16; i++) pix.push_back(DW'(i));
        applyStimulus("after_reset", 0, 4, 4, pix, 0);
    endtask

    task automatic test_back_to_back();
        logic signed [DW-1:0] pix[$];
        for (int i = 1; i <= 16; i++) pix.push_back(DW'(i));
        for (int i = 101; i <= 116; i++) pix.push_back(DW'(i));
        applyStimulus("back_to_back", 0, 4, 4, pix, 0);
    endtask

    task automatic test_random();
        logic signed [DW-1:0] pix[$];
        for (int i = 0; i < 48; i++) pix.push_back(DW'($urandom));
        applyStimulus("random_4x4", 0, 4, 4, pix, 2);
        pix.delete();
        for (int i = 0; i < 45; i++) pix.push_back(DW'($urandom));
        applyStimulus("random_5x3", 2, 5, 3, pix, 2);
        pix.delete();
        for (int i = 0; i < 12; i++) pix.push_back(DW'($urandom));
        applyStimulus("random_2x2", 1, 2, 2, pix, 1);
    endtask

    task automatic checkOutput();
        checks++;
        if (strayFd !== 0) begin
            errors++;
            $display("[TB] FAIL frame_done without out_valid: got %0d expected 0", strayFd);
        end
    endtask

    initial begin
        test_reset();
        test_continuous();
        test_gaps();
        test_signed();
        test_odd_dims();
        test_reset_mid_frame();
        test_back_to_back();
        test_random();
        checkOutput();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/pool2x2_window_gen.md
Name: pool2x2_window_gen

Overview:
- Producer side of the 2x2 max-pool interface. Accepts a raster-order pixel stream from the conv/activation stage, one signed pixel per beat, and buffers one line internally.
- Emits each non-overlapping, stride-2, 2x2 window as p00/p01/p10/p11 with a single-cycle out_valid pulse, which drives the pooling unit's in_valid.
- Sits directly in front of maxpool2x2 in the feature-map datapath.

Parameters:
- DATA_W, 8, signed pixel width.
- IMG_W, 28, feature-map width in pixels. Must be at least 2.
- IMG_H, 28, feature-map height in pixels. Must be at least 2.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset.
- in_valid  input  1  in_data is a valid pixel this cycle. The block has no backpressure; every valid beat is accepted.
- in_data  input  DATA_W  signed pixel in raster order (row-major, top-left first).
- p00  output  DATA_W  window top-left (row 2r, col 2c).
- p01  output  DATA_W  window top-right (row 2r, col 2c+1).
- p10  output  DATA_W  window bottom-left (row 2r+1, col 2c).
- p11  output  DATA_W  window bottom-right (row 2r+1, col 2c+1).
- out_valid  output  1  one-cycle pulse; p00..p11 form a complete window.
- frame_done  output  1  one-cycle pulse, coincident with the out_valid of the frame's last window.

Behaviour:
- Reset (rst low, asynchronous): p00..p11 = 0, out_valid = 0, frame_done = 0, col = 0, row = 0, hold register = 0. Line-buffer contents are don't-care.
- Counters:
  - col runs 0..IMG_W-1 and row runs 0..IMG_H-1. Both advance only on in_valid = 1.
  - col wraps to 0 at IMG_W-1 and increments row at that point.
  - row wraps to 0 after the last pixel of the frame.
  - Counter width is $clog2 of the respective dimension, minimum 1.
- Even row (row[0] = 0): write in_data into linebuf[col]. Nothing is emitted.
- Odd row, even col: capture in_data into the hold register.
- Odd row, odd col: this is the window-complete beat. On the next rising edge, register:
  - p00 = linebuf[col-1], p01 = linebuf[col]
  - p10 = hold, p11 = in_data
  - out_valid = 1
- Latency: out_valid is high in the cycle after the beat that carried p11.
- out_valid is low in every cycle that does not follow a window-complete beat. p00..p11 hold their last window values while out_valid is low.
- Odd dimensions:
  - If IMG_W is odd, the last column (col = IMG_W-1) is consumed but produces no window.
  - If IMG_H is odd, the last row is consumed and written to the line buffer but produces no window.
  - Counters still wrap at the full IMG_W/IMG_H.
  - Windows per frame = floor(IMG_W/2) * floor(IMG_H/2).
- frame_done asserts together with out_valid for window (floor(IMG_H/2)-1, floor(IMG_W/2)-1). It does not depend on whether the trailing odd row/column has been consumed.
- Gaps: in_valid may drop for any number of cycles. State holds and no window is lost or duplicated.
- Back-to-back frames: the first pixel of the next frame may arrive in the cycle after the last pixel, with no bubble required.
- Reset mid-frame: the partial frame is discarded. The first post-reset pixel is treated as (row 0, col 0).
- Arithmetic: no arithmetic on data; pixels pass through bit-exact, sign preserved.
- Storage: linebuf has IMG_W entries of DATA_W bits, with one write port and two read addresses (col-1, col). A register array or a dual-read memory is acceptable.

Test Plan:
1. IMG_W = 4, IMG_H = 4, pixels 1..16 streamed continuously -> four out_valid pulses in order with windows (1,2,5,6), (3,4,7,8), (9,10,13,14), (11,12,15,16). frame_done is asserted with the fourth pulse only. Each pulse occurs 1 cycle after the pixels 6, 8, 14, 16 are accepted.
2. Same frame with in_valid randomly deasserted (for example, 1 cycle idle between every beat) -> identical window sequence, and no out_valid during gaps.
3. Signed data, IMG_W = 2, IMG_H = 2, pixels -8, -5, -10, -3 -> exactly one window (-8, -5, -10, -3), sign bits intact.
4. IMG_W = 5, IMG_H = 3, pixels 1..15 -> exactly two windows: (1,2,6,7) and (3,4,8,9). frame_done is asserted with the second window. Pixels 5, 10 and 11..15 produce no output.
5. Assert rst low mid-frame after pixel 6 of test 1 -> out_valid and outputs go to 0 asynchronously. Then stream 1..16 -> the four windows of test 1, with no stale data.
6. Two back-to-back 4x4 frames (1..16, then 101..116) with no idle cycle -> eight windows, the second set starting (101,102,105,106). frame_done pulses twice.
